// File: rtl/regfile_fifo_ctrl.sv
// Valid/ready FIFO front-end for the 32x4 register-file BEL: drives its write port and port-A address, aligns pop data with port-A latency.
// Optional macro REGFILE_FIFO_ALMOST_EN adds almost_full/almost_empty flags with AF_THRESH/AE_THRESH.
module regfile_fifo_ctrl #(
    parameter int unsigned NoConfigBits = 2,
    parameter int unsigned DEPTH        = 32
`ifdef REGFILE_FIFO_ALMOST_EN
    ,
    parameter int unsigned AF_THRESH    = 28,
    parameter int unsigned AE_THRESH    = 2
`endif
) (
    input  logic                    UserCLK,
    input  logic                    Reset,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [3:0]              push_data,
    output logic                    pop_valid,
    input  logic                    pop_ready,
    output logic [3:0]              pop_data,
    output logic [5:0]              count,
    output logic                    overflow,
    output logic [3:0]              RF_D,
    output logic [4:0]              RF_W_ADR,
    output logic                    RF_W_en,
    output logic [4:0]              RF_A_ADR,
    input  logic [3:0]              RF_AD,
    input  logic [NoConfigBits-1:0] ConfigBits
`ifdef REGFILE_FIFO_ALMOST_EN
    ,
    output logic                    almost_full,
    output logic                    almost_empty
`endif
);

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        OS_EMPTY = 2'd0,
        OS_WAIT  = 2'd1,
        OS_VALID = 2'd2
    } os_state_t;

    os_state_t       r_os_state;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [DW-1:0]   r_pop_data;
    logic            r_pop_valid;
    logic            r_overflow;

    logic [PW-1:0]   w_mem_cnt;
    logic            w_full;
    logic            w_avail;
    logic            w_accept;
    logic            w_reg_a;
    logic            w_drop;

    // Status derived from the pointer pair; the wrap bit disambiguates full from empty.
    assign w_mem_cnt = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_mem_cnt == PW'(DEPTH));
    assign w_avail   = (w_mem_cnt != '0);
    assign w_reg_a   = ConfigBits[0];
    assign w_drop    = ConfigBits[1];
    assign w_accept  = push_valid && !w_full && !Reset;

    assign RF_W_en    = w_accept;
    assign RF_W_ADR   = r_wr_ptr[AW-1:0];
    assign RF_D       = push_data;
    assign RF_A_ADR   = r_rd_ptr[AW-1:0];

    assign push_ready = w_drop ? 1'b1 : !w_full;
    assign pop_valid  = r_pop_valid;
    assign pop_data   = r_pop_data;
    assign overflow   = r_overflow;
    assign count      = w_mem_cnt + PW'(r_pop_valid);

`ifdef REGFILE_FIFO_ALMOST_EN
    assign almost_full  = (32'(count) >= AF_THRESH);
    assign almost_empty = (32'(count) <= AE_THRESH);
`endif

    // Pointers, sticky drop flag and output-stage FSM; WAIT covers the registered port-A cycle.
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_os_state  <= OS_EMPTY;
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_drop && push_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            case (r_os_state)
                OS_EMPTY: begin
                    if (w_avail) begin
                        if (w_reg_a) begin
                            r_os_state <= OS_WAIT;
                        end else begin
                            r_pop_data  <= RF_AD;
                            r_rd_ptr    <= r_rd_ptr + PW'(1);
                            r_os_state  <= OS_VALID;
                            r_pop_valid <= 1'b1;
                        end
                    end
                end
                OS_WAIT: begin
                    r_pop_data  <= RF_AD;
                    r_rd_ptr    <= r_rd_ptr + PW'(1);
                    r_os_state  <= OS_VALID;
                    r_pop_valid <= 1'b1;
                end
                OS_VALID: begin
                    if (pop_ready) begin
                        if (!w_avail) begin
                            r_os_state  <= OS_EMPTY;
                            r_pop_valid <= 1'b0;
                        end else if (w_reg_a) begin
                            r_os_state  <= OS_WAIT;
                            r_pop_valid <= 1'b0;
                        end else begin
                            r_pop_data <= RF_AD;
                            r_rd_ptr   <= r_rd_ptr + PW'(1);
                        end
                    end
                end
                default: begin
                    r_os_state  <= OS_EMPTY;
                    r_pop_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Bench for regfile_fifo_ctrl: vector table, directed corner sequences and randomized traffic against a timing-rule FIFO model.
module tb_regfile_fifo_ctrl;

    logic       clk = 1'b0;
    logic       Reset;
    logic       push_valid;
    logic       push_ready;
    logic [3:0] push_data;
    logic       pop_valid;
    logic       pop_ready;
    logic [3:0] pop_data;
    logic [5:0] count;
    logic       overflow;
    logic [3:0] RF_D;
    logic [4:0] RF_W_ADR;
    logic       RF_W_en;
    logic [4:0] RF_A_ADR;
    logic [3:0] RF_AD;
    logic [1:0] cfg;
`ifdef REGFILE_FIFO_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    always #5 clk = ~clk;

    regfile_fifo_ctrl dut (
        .UserCLK    (clk),
        .Reset      (Reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count),
        .overflow   (overflow),
        .RF_D       (RF_D),
        .RF_W_ADR   (RF_W_ADR),
        .RF_W_en    (RF_W_en),
        .RF_A_ADR   (RF_A_ADR),
        .RF_AD      (RF_AD),
        .ConfigBits (cfg)
`ifdef REGFILE_FIFO_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // Register-file BEL model: synchronous write, port A either combinational or registered.
    logic [3:0] rf_mem [32];
    logic [3:0] rf_ad_q;
    always @(posedge clk) begin
        if (RF_W_en) rf_mem[RF_W_ADR] <= RF_D;
        rf_ad_q <= rf_mem[RF_A_ADR];
    end
    assign RF_AD = cfg[0] ? rf_ad_q : rf_mem[RF_A_ADR];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // FIFO model: ordered items with the cycle they become countable; visibility follows the latency rules.
    typedef struct {
        logic [3:0] d;
        int         ew;
    } item_t;
    item_t q[$];
    int    wr_total;
    int    last_pop;
    logic  exp_ovf;

    task automatic step(input logic pv, input logic [3:0] pd, input logic pr);
        int   sz;
        int   vis;
        int   k;
        logic epv;
        logic efull;
        logic acc;
        item_t it;
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
        k   = cyc;
        sz  = q.size();
        epv = 1'b0;
        if (sz > 0) begin
            vis = ((q[0].ew > last_pop) ? q[0].ew : last_pop) + (cfg[0] ? 2 : 1);
            epv = (k >= vis);
        end
        efull = ((sz - int'(epv)) == 32);
        acc   = pv && !efull;
        chk("count", int'(count), sz);
        chk("pop_valid", int'(pop_valid), int'(epv));
        if (epv && pop_valid) chk("pop_data", int'(pop_data), int'(q[0].d));
        chk("push_ready", int'(push_ready), cfg[1] ? 1 : int'(!efull));
        chk("rf_w_en", int'(RF_W_en), int'(acc));
        if (acc) begin
            chk("rf_w_adr", int'(RF_W_ADR), wr_total % 32);
            chk("rf_d", int'(RF_D), int'(pd));
        end
        chk("overflow", int'(overflow), int'(exp_ovf));
`ifdef REGFILE_FIFO_ALMOST_EN
        chk("almost_full", int'(almost_full), int'(sz >= 28));
        chk("almost_empty", int'(almost_empty), int'(sz <= 2));
`endif
        @(posedge clk);
        if (epv && pr) begin
            void'(q.pop_front());
            last_pop = k;
        end
        if (acc) begin
            it.d  = pd;
            it.ew = k + 1;
            q.push_back(it);
            wr_total++;
        end
        if (cfg[1] && pv && efull) exp_ovf = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset      = 1'b1;
        push_valid = 1'b1;
        push_data  = 4'hF;
        pop_ready  = 1'b0;
        #1;
        chk("rst_w_en", int'(RF_W_en), 0);
        @(posedge clk);
        #1;
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
`ifdef REGFILE_FIFO_ALMOST_EN
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_almost_empty", int'(almost_empty), 1);
`endif
        @(negedge clk);
        Reset      = 1'b0;
        push_valid = 1'b0;
        q.delete();
        wr_total = 0;
        exp_ovf  = 1'b0;
        last_pop = -1000;
    endtask

    typedef struct {
        logic [1:0] cfg;
        logic       pv;
        logic [3:0] pd;
        logic       pr;
        logic       epv;
        logic [3:0] epd;
        logic [5:0] ecnt;
        logic       epr;
        logic       ewen;
    } vec_t;
    vec_t vecs [13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 4'h0;
        Reset      = 1'b1;
        push_valid = 1'b0;
        push_data  = 4'h0;
        pop_ready  = 1'b0;
        cfg        = 2'b00;
        wr_total   = 0;
        exp_ovf    = 1'b0;
        last_pop   = -1000;

        // cfg, pv, pd, pr | pop_valid, pop_data, count, push_ready, RF_W_en
        vecs[0]  = '{2'd0, 1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 6'd0, 1'b1, 1'b1};
        vecs[1]  = '{2'd0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 6'd1, 1'b1, 1'b1};
        vecs[2]  = '{2'd0, 1'b1, 4'h3, 1'b1, 1'b1, 4'h1, 6'd2, 1'b1, 1'b1};
        vecs[3]  = '{2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 6'd2, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 6'd1, 1'b1, 1'b0};
        vecs[5]  = '{2'd0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 6'd0, 1'b1, 1'b0};
        vecs[6]  = '{2'd1, 1'b1, 4'hA, 1'b1, 1'b0, 4'h0, 6'd0, 1'b1, 1'b1};
        vecs[7]  = '{2'd1, 1'b1, 4'hB, 1'b1, 1'b0, 4'h0, 6'd1, 1'b1, 1'b1};
        vecs[8]  = '{2'd1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 6'd2, 1'b1, 1'b0};
        vecs[9]  = '{2'd1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hA, 6'd2, 1'b1, 1'b0};
        vecs[10] = '{2'd1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 6'd1, 1'b1, 1'b0};
        vecs[11] = '{2'd1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hB, 6'd1, 1'b1, 1'b0};
        vecs[12] = '{2'd1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 6'd0, 1'b1, 1'b0};

        for (int i = 0; i < 13; i++) begin
            if (i == 0 || vecs[i].cfg != vecs[i-1].cfg) begin
                cfg = vecs[i].cfg;
                do_reset();
            end
            @(negedge clk);
            push_valid = vecs[i].pv;
            push_data  = vecs[i].pd;
            pop_ready  = vecs[i].pr;
            #1;
            chk($sformatf("vec%0d_pop_valid", i), int'(pop_valid), int'(vecs[i].epv));
            if (vecs[i].epv) chk($sformatf("vec%0d_pop_data", i), int'(pop_data), int'(vecs[i].epd));
            chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].ecnt));
            chk($sformatf("vec%0d_push_ready", i), int'(push_ready), int'(vecs[i].epr));
            chk($sformatf("vec%0d_rf_w_en", i), int'(RF_W_en), int'(vecs[i].ewen));
            @(posedge clk);
        end

        // Fill past capacity with the consumer stalled, then drain in order.
        cfg = 2'b00;
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 4'(i), 1'b0);
        #1;
        chk("fill_count", int'(count), 33);
        chk("fill_push_ready", int'(push_ready), 0);
        for (int i = 0; i < 35; i++) step(1'b0, 4'h0, 1'b1);

        // Drop mode: extra pushes while full are discarded and flagged.
        cfg = 2'b10;
        do_reset();
        for (int i = 0; i < 33; i++) step(1'b1, 4'(i & 7), 1'b0);
        step(1'b1, 4'hC, 1'b0);
        step(1'b1, 4'hD, 1'b0);
        step(1'b1, 4'hE, 1'b0);
        #1;
        chk("drop_overflow", int'(overflow), 1);
        chk("drop_count", int'(count), 33);
        step(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 21; i++) step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        #1;
        chk("pre_rst_count", int'(count), 12);
        chk("pre_rst_pop_valid", int'(pop_valid), 1);

        // Reset mid-transfer, then a fresh push must come out intact.
        do_reset();
        step(1'b1, 4'h7, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1);

        // Simultaneous push/pop at occupancy 5 across the pointer wrap.
        cfg = 2'b00;
        do_reset();
        for (int i = 0; i < 28; i++) step(1'b1, 4'(i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'(i + 9), 1'b1);
            #1;
            chk("simul_count", int'(count), 5);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1);

        // Randomized traffic in every configuration, phases biased toward full, empty and mixed.
        for (int c = 0; c < 4; c++) begin
            cfg = 2'(c);
            do_reset();
            for (int n = 0; n < 1200; n++) begin
                int ph;
                int tp;
                int tr;
                ph = (n / 150) % 3;
                tp = (ph == 0) ? 90 : ((ph == 1) ? 30 : 60);
                tr = (ph == 0) ? 15 : ((ph == 1) ? 90 : 60);
                step(($urandom_range(0, 99) < tp), 4'($urandom), ($urandom_range(0, 99) < tr));
            end
            for (int n = 0; n < 70; n++) step(1'b0, 4'h0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
